// File: rtl/pu_tile_scheduler.sv
// pu_tile_scheduler: sequences processing_unit over a layer split into tiles.
// For each tile the operands are loaded, the PU is cleared, the PU is run
// until it reports done, and its output words are drained. The block
// produces control only and carries no datapath.
// Every output is registered (Moore). Outputs are decoded from the next
// state, so each one changes on the same edge as the state it belongs to.
// Optional feature: define SCHED_WATCHDOG_EN to enable the RUN watchdog
// (err_timeout). Without it, err_timeout is tied low and RUN waits for
// pu_done indefinitely.
module pu_tile_scheduler #(
    parameter int TILE_W      = 8,
    parameter int DRAIN_COUNT = 16,
    parameter int DRAIN_W     = (DRAIN_COUNT > 1) ? $clog2(DRAIN_COUNT) : 1,
    parameter int RUN_MIN     = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [TILE_W-1:0] num_tiles,
    output logic              busy,
    output logic              layer_done,
    output logic [TILE_W-1:0] tile_idx,
    output logic              load_req,
    output logic [TILE_W-1:0] load_tile,
    input  logic              load_ack,
    output logic              pu_reset,
    output logic              pu_enable,
    input  logic              pu_done,
    output logic              drain_valid,
    output logic [DRAIN_W-1:0] drain_idx,
    input  logic              drain_ready,
    output logic              err_timeout
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_CLEAR = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    // The RUN counter only has to reach RUN_MIN, unless the watchdog needs
    // it to count all the way to the timeout limit.
`ifdef SCHED_WATCHDOG_EN
    localparam int RUN_LIM = (TIMEOUT_CYC > RUN_MIN) ? TIMEOUT_CYC : RUN_MIN;
`else
    localparam int RUN_LIM = RUN_MIN;
`endif
    localparam int RUN_W = $clog2(RUN_LIM + 1);

    localparam logic [RUN_W-1:0]   RUN_MIN_C  = RUN_W'(RUN_MIN);
    localparam logic [RUN_W-1:0]   RUN_LIM_C  = RUN_W'(RUN_LIM);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_COUNT - 1);

    logic [2:0]        state;
    logic [2:0]        state_n;
    logic [TILE_W-1:0] num_lat;
    logic [RUN_W-1:0]  run_cnt;

    logic done_ok;      // pu_done is trusted only after RUN_MIN RUN cycles
    logic drain_fire;   // output word accepted this cycle
    logic drain_last;   // final word of the tile accepted this cycle
    logic last_tile;    // current tile is the last one of the layer
    logic zero_layer;   // start with an empty layer: pulse done, stay idle
    logic accept_start; // start taken with a non-empty layer
`ifdef SCHED_WATCHDOG_EN
    logic timeout_hit;  // RUN has used its whole cycle budget without done
`endif

    // Next-state and handshake decode.
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves a value unassigned and no latch is inferred.
        done_ok      = pu_done && (run_cnt >= RUN_MIN_C);
        drain_fire   = drain_valid && drain_ready;
        drain_last   = drain_fire && (drain_idx == DRAIN_LAST);
        last_tile    = (tile_idx == (num_lat - TILE_W'(1)));
        zero_layer   = (state == S_IDLE) && start && (num_tiles == '0);
        accept_start = (state == S_IDLE) && start && (num_tiles != '0);
`ifdef SCHED_WATCHDOG_EN
        timeout_hit  = (state == S_RUN) && !done_ok &&
                       (run_cnt >= RUN_W'(TIMEOUT_CYC - 1));
`endif
        state_n      = state;

        case (state)
            S_IDLE:  if (accept_start) state_n = S_LOAD;
            S_LOAD:  if (load_ack) state_n = S_CLEAR;
            S_CLEAR: state_n = S_RUN;
            S_RUN: begin
                if (done_ok) begin
                    state_n = S_DRAIN;
                end
`ifdef SCHED_WATCHDOG_EN
                else if (timeout_hit) begin
                    state_n = S_DONE;
                end
`endif
            end
            S_DRAIN: if (drain_last) state_n = last_tile ? S_DONE : S_LOAD;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        // Abort wins over every handshake; in IDLE there is nothing to abort.
        if (abort && (state != S_IDLE)) state_n = S_IDLE;
    end

    // State, registered outputs and counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            layer_done  <= 1'b0;
            load_req    <= 1'b0;
            pu_reset    <= 1'b0;
            pu_enable   <= 1'b0;
            drain_valid <= 1'b0;
            drain_idx   <= '0;
            tile_idx    <= '0;
            num_lat     <= '0;
            run_cnt     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values, whatever the statement order.
            state       <= state_n;
            busy        <= (state_n != S_IDLE);
            layer_done  <= (state_n == S_DONE) || zero_layer;
            load_req    <= (state_n == S_LOAD);
            pu_reset    <= (state_n == S_CLEAR);
            pu_enable   <= (state_n == S_RUN);
            drain_valid <= (state_n == S_DRAIN);

            if (accept_start) num_lat <= num_tiles;

            // Tile index restarts on every return to idle and advances
            // when a finished tile hands over to the next load.
            if (state_n == S_IDLE) begin
                tile_idx <= '0;
            end else if ((state == S_DRAIN) && (state_n == S_LOAD)) begin
                tile_idx <= tile_idx + TILE_W'(1);
            end

            // Drain index holds while stalled and restarts for every tile.
            if (state_n != S_DRAIN) begin
                drain_idx <= '0;
            end else if (drain_fire) begin
                drain_idx <= drain_idx + DRAIN_W'(1);
            end

            // RUN cycle counter: cleared in CLEAR, saturates while running.
            if (state == S_CLEAR) begin
                run_cnt <= '0;
            end else if ((state == S_RUN) && (run_cnt != RUN_LIM_C)) begin
                run_cnt <= run_cnt + RUN_W'(1);
            end
        end
    end

    assign load_tile = tile_idx;

`ifdef SCHED_WATCHDOG_EN
    // Sticky watchdog flag: set on a RUN timeout, cleared by the next layer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_timeout <= 1'b0;
        end else if (accept_start) begin
            err_timeout <= 1'b0;
        end else if (timeout_hit && !abort) begin
            err_timeout <= 1'b1;
        end
    end
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pu_tile_scheduler.sv
// Testbench for pu_tile_scheduler: a behavioural loader / PU / consumer
// drives the handshakes with random timing, and every tile is checked
// against the expected layer sequence (tile order, latencies, run length,
// drain order and count, layer_done pulse, abort and reset behaviour).
module tb_pu_tile_scheduler;

    localparam int TILE_W      = 8;
    localparam int DRAIN_COUNT = 16;
    localparam int DRAIN_W     = 4;
    localparam int RUN_MIN     = 2;
    localparam int TIMEOUT_CYC = 4096;
    localparam int RUN_BOUND   = 6000;
    localparam int DRAIN_BOUND = 2000;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [TILE_W-1:0] num_tiles = '0;
    logic              busy;
    logic              layer_done;
    logic [TILE_W-1:0] tile_idx;
    logic              load_req;
    logic [TILE_W-1:0] load_tile;
    logic              load_ack = 1'b0;
    logic              pu_reset;
    logic              pu_enable;
    logic              pu_done = 1'b0;
    logic              drain_valid;
    logic [DRAIN_W-1:0] drain_idx;
    logic              drain_ready = 1'b0;
    logic              err_timeout;

    int n_checks = 0;
    int n_errors = 0;

    pu_tile_scheduler #(
        .TILE_W(TILE_W), .DRAIN_COUNT(DRAIN_COUNT), .DRAIN_W(DRAIN_W),
        .RUN_MIN(RUN_MIN), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .num_tiles(num_tiles), .busy(busy), .layer_done(layer_done),
        .tile_idx(tile_idx), .load_req(load_req), .load_tile(load_tile),
        .load_ack(load_ack), .pu_reset(pu_reset), .pu_enable(pu_enable),
        .pu_done(pu_done), .drain_valid(drain_valid), .drain_idx(drain_idx),
        .drain_ready(drain_ready), .err_timeout(err_timeout)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock; outputs are sampled and inputs changed on the falling edge.
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    function automatic logic ready_for(input int pct, input int cyc);
        if (pct < 0) return ((cyc % 4) == 0) || ((cyc % 4) == 3); // 1,0,0,1
        return ($urandom_range(0, 99) < pct);
    endfunction

    // After an abort: idle next cycle, no pulses of any kind afterwards.
    task automatic abort_checks();
        abort = 1'b0; load_ack = 1'b0; pu_done = 1'b0; drain_ready = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_load_req", load_req, 0);
        check("abort_pu_enable", pu_enable, 0);
        check("abort_drain_valid", drain_valid, 0);
        for (int i = 0; i < 3; i++) begin
            check("abort_layer_done", layer_done, 0);
            check("abort_pu_reset", pu_reset, 0);
            step();
            check("abort_idle_busy", busy, 0);
        end
    endtask

    // Run one layer of n tiles. ack_min/ack_max: load wait cycles before
    // load_ack; done_d: PU raises done after done_d enabled cycles (0 =
    // held high from CLEAR); ready_pct: consumer ready probability, or -1
    // for the fixed 1,0,0,1 pattern. ab_tile/ab_phase inject an abort
    // together with the load_ack (0), the accepted pu_done (1) or a drain
    // accept (2) of tile ab_tile.
    task automatic run_layer(input int n, input int ack_min, input int ack_max,
                             input int done_d, input int ready_pct,
                             input int ab_tile, input int ab_phase);
        int exp_en;
        int en;
        int acc;
        int cyc;
        int waits;
        logic r;

        exp_en = (done_d > RUN_MIN + 1) ? done_d : RUN_MIN + 1;
`ifdef SCHED_WATCHDOG_EN
        if (exp_en > TIMEOUT_CYC) exp_en = TIMEOUT_CYC;
`endif
        start = 1'b1;
        num_tiles = TILE_W'(n);
        step();
        start = 1'b0;
        num_tiles = TILE_W'($urandom);   // must be ignored from now on

        if (n == 0) begin
            check("zero_layer_done", layer_done, 1);
            check("zero_busy", busy, 0);
            check("zero_load_req", load_req, 0);
            step();
            check("zero_done_off", layer_done, 0);
            check("zero_busy2", busy, 0);
            check("zero_load_req2", load_req, 0);
            return;
        end

        check("start_busy", busy, 1);
        check("start_err_clear", err_timeout, 0);
        for (int t = 0; t < n; t++) begin
            check("load_req", load_req, 1);
            check("load_tile", load_tile, t);
            check("tile_idx", tile_idx, t);
            check("load_pu_enable", pu_enable, 0);
            check("load_drain_valid", drain_valid, 0);

            waits = $urandom_range(ack_min, ack_max);
            for (int w = 0; w < waits; w++) begin
                start = 1'($urandom_range(0, 1));  // ignored while busy
                step();
                check("load_req_hold", load_req, 1);
                check("load_tile_hold", load_tile, t);
            end
            start = 1'b0;
            load_ack = 1'b1;
            if (t == ab_tile && ab_phase == 0) abort = 1'b1;
            step();
            load_ack = 1'b0;
            if (abort) begin
                abort_checks();
                return;
            end
            check("clear_load_req", load_req, 0);
            check("clear_pu_reset", pu_reset, 1);
            check("clear_pu_enable", pu_enable, 0);
            pu_done = (done_d == 0);
            step();
            check("run_pu_reset", pu_reset, 0);
            check("run_pu_enable", pu_enable, 1);

            en = 0;
            while (pu_enable && en < RUN_BOUND) begin
                en++;
                pu_done = (en >= done_d);
                if (t == ab_tile && ab_phase == 1 && en == exp_en) abort = 1'b1;
                step();
                if (abort) begin
                    abort_checks();
                    return;
                end
            end
            pu_done = 1'b0;
            check("run_cycles", en, exp_en);
`ifdef SCHED_WATCHDOG_EN
            if (done_d > TIMEOUT_CYC) begin
                check("wd_layer_done", layer_done, 1);
                check("wd_err", err_timeout, 1);
                check("wd_no_drain", drain_valid, 0);
                step();
                check("wd_busy_off", busy, 0);
                check("wd_err_sticky", err_timeout, 1);
                return;
            end
`endif
            check("drain_pu_enable", pu_enable, 0);

            acc = 0;
            cyc = 0;
            while (acc < DRAIN_COUNT && cyc < DRAIN_BOUND) begin
                check("drain_valid", drain_valid, 1);
                check("drain_idx", drain_idx, acc);
                r = ready_for(ready_pct, cyc);
                drain_ready = r;
                if (t == ab_tile && ab_phase == 2 && acc == 5 && r) abort = 1'b1;
                step();
                cyc++;
                if (abort) begin
                    abort_checks();
                    return;
                end
                if (r) acc++;
            end
            drain_ready = 1'b0;
            check("drain_accepts", acc, DRAIN_COUNT);
            check("drain_no_done_early", layer_done, (t == n - 1) ? 1 : 0);
        end

        check("done_busy", busy, 1);
        check("done_drain_valid", drain_valid, 0);
        check("done_load_req", load_req, 0);
        step();
        check("done_pulse_off", layer_done, 0);
        check("done_busy_off", busy, 0);
    endtask

    initial begin
        int n;
        int ab_tile;
        int guard;

        // Reset state.
        #12;
        check("rst_busy", busy, 0);
        check("rst_layer_done", layer_done, 0);
        check("rst_load_req", load_req, 0);
        check("rst_pu_reset", pu_reset, 0);
        check("rst_pu_enable", pu_enable, 0);
        check("rst_drain_valid", drain_valid, 0);
        check("rst_drain_idx", drain_idx, 0);
        check("rst_tile_idx", tile_idx, 0);
        check("rst_err", err_timeout, 0);
        @(negedge clock);
        reset = 1'b1;
        step();

        // Abort while idle does nothing.
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("idle_abort_busy", busy, 0);
        check("idle_abort_done", layer_done, 0);

        // Directed cases.
        run_layer(3, 2, 2, 10, 100, -1, 0);   // nominal three-tile layer
        run_layer(0, 0, 0, 0, 100, -1, 0);    // empty layer
        run_layer(1, 0, 0, 0, 100, -1, 0);    // pu_done held from CLEAR
        run_layer(1, 1, 1, 4, -1, -1, 0);     // ready pattern 1,0,0,1
        run_layer(3, 0, 2, 5, 100, 1, 0);     // abort with load_ack, tile 1
        run_layer(2, 0, 1, 6, 100, 0, 1);     // abort with accepted pu_done
        run_layer(2, 0, 1, 3, 70, 1, 2);      // abort with a drain accept

        // Asynchronous reset in the middle of a tile.
        start = 1'b1;
        num_tiles = 8'd2;
        step();
        start = 1'b0;
        load_ack = 1'b1;
        step();
        load_ack = 1'b0;
        guard = 0;
        while (!pu_enable && guard < 10) begin
            step();
            guard++;
        end
        check("mid_reset_running", pu_enable, 1);
        reset = 1'b0;
        #1;
        check("mid_reset_busy", busy, 0);
        check("mid_reset_pu_enable", pu_enable, 0);
        check("mid_reset_tile_idx", tile_idx, 0);
        @(negedge clock);
        reset = 1'b1;
        step();
        run_layer(1, 0, 1, 2, 100, -1, 0);    // CLEAR is redone after reset

`ifdef SCHED_WATCHDOG_EN
        run_layer(1, 0, 0, 1000000, 100, -1, 0); // pu_done stuck low
        run_layer(1, 0, 0, 3, 100, -1, 0);       // next start clears err
`endif

        // Randomized layers.
        for (int k = 0; k < 12; k++) begin
            n = $urandom_range(1, 4);
            ab_tile = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
            run_layer(n, 0, 3, $urandom_range(0, 12), $urandom_range(30, 100),
                      ab_tile, $urandom_range(0, 2));
            for (int i = 0; i < $urandom_range(0, 2); i++) step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "time limit reached");
    end

endmodule
